// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
package pipe_pkg;

    localparam int unsigned PIPE_CNT_W = 2;

    // Encoding doubles as the occupancy count.
    typedef enum logic [PIPE_CNT_W-1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } pipe_state_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush (bubble) and hold
// (stall). Define PIPE_SKID_EN to add a second (skid) entry, which makes
// in_ready independent of out_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter bit          ZERO_DATA = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  hold,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [PIPE_CNT_W-1:0] count
);

    pipe_state_t       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] skid_q, skid_d;
`endif
    logic              in_fire;
    logic              out_fire;

    // Handshake: ready/valid and the fire qualifiers for both sides.
    always_comb begin
`ifdef PIPE_SKID_EN
        in_ready  = ~flush & ~hold & (state_q != FULL);
`else
        in_ready  = ~flush & ~hold & ((state_q == EMPTY) | out_ready);
`endif
        out_valid = (state_q != EMPTY);
        in_fire   = in_valid & in_ready;
        out_fire  = out_valid & out_ready & ~hold & ~flush;
    end

    assign out_data = main_q;
    assign count    = state_q;

    // Next-state and payload steering; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            state_d = EMPTY;
            if (ZERO_DATA) begin
                main_d = '0;
`ifdef PIPE_SKID_EN
                skid_d = '0;
`endif
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end
`ifdef PIPE_SKID_EN
                    else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end
`endif
                    else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
`ifdef PIPE_SKID_EN
                FULL: begin
                    // Skid entry is always the newer one, so it moves up.
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
`endif
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and payload registers; reset clears payload regardless of ZERO_DATA.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
`ifdef PIPE_SKID_EN
            skid_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef PIPE_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

endmodule
